// File: rtl/conv2d_pixel_feeder.sv
// conv2d_pixel_feeder
//   Buffers one IMG_W x IMG_H frame of DATA_W-bit pixels and streams it in
//   raster order to a convolution engine. It then waits for the engine's
//   completion flag before accepting the next frame.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset; also clears the frame buffer
//   wr_en        frame-buffer write strobe (honoured only in IDLE without go)
//   wr_addr      raster pixel address
//   wr_data      pixel value
//   go           start streaming one frame (IDLE only)
//   abort        cancel the frame in progress
//   conv_start   pixel-valid strobe to the engine
//   conv_data    streamed pixel (0 when not streaming)
//   conv_done    engine completion flag (only looked at in WAIT_DONE)
//   busy         registered, high in STREAM / WAIT_DONE
//   frame_done   one-cycle completion pulse
//   timeout_err  sticky "conv_done never arrived" flag
//
// Build option
//   FEEDER_TIMEOUT_EN : when defined, WAIT_DONE gives up after DONE_TIMEOUT
//                       cycles and sets timeout_err. When undefined, WAIT_DONE
//                       waits forever and timeout_err is tied to 0.

module conv2d_pixel_feeder #(
   parameter int IMG_W        = 5,
   parameter int IMG_H        = 5,
   parameter int DATA_W       = 8,
   parameter int DONE_TIMEOUT = 64
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             wr_en,
   input  logic [$clog2(IMG_W*IMG_H)-1:0]   wr_addr,
   input  logic [DATA_W-1:0]                wr_data,
   input  logic                             go,
   input  logic                             abort,
   output logic                             conv_start,
   output logic [DATA_W-1:0]                conv_data,
   input  logic                             conv_done,
   output logic                             busy,
   output logic                             frame_done,
   output logic                             timeout_err
);

   localparam int N  = IMG_W * IMG_H;
   localparam int AW = $clog2(N);
   localparam int TW = $clog2(DONE_TIMEOUT + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;

   logic [DATA_W-1:0] mem_q [N];

   logic [1:0]        state_q, state_d;
   logic [AW-1:0]     idx_q, idx_d;     // index of the pixel currently on conv_data
   logic [TW-1:0]     tcnt_q, tcnt_d;   // cycles spent in WAIT_DONE (saturating)
   logic              start_q, start_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              busy_q, busy_d;
   logic              fd_q, fd_d;
   logic              wr_ok;

   // The address check is done one bit wider so N == 2**AW still compares right.
   assign wr_ok = wr_en && (state_q == S_IDLE) && !go &&
                  ({1'b0, wr_addr} < (AW+1)'(N));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      tcnt_d  = tcnt_q;
      start_d = start_q;
      data_d  = data_q;
      fd_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (go) begin
               // pixel 0 is registered on the go edge so it shows one cycle later
               state_d = S_STREAM;
               idx_d   = '0;
               start_d = 1'b1;
               data_d  = mem_q[0];
            end
         end
         S_STREAM: begin
            if (abort) begin
               state_d = S_IDLE;
               idx_d   = '0;
               start_d = 1'b0;
               data_d  = '0;
            end else if (idx_q == AW'(N-1)) begin
               state_d = S_WAIT;
               idx_d   = '0;
               tcnt_d  = '0;
               start_d = 1'b0;
               data_d  = '0;
            end else begin
               idx_d  = idx_q + AW'(1);
               data_d = mem_q[idx_q + AW'(1)];
            end
         end
         S_WAIT: begin
            if (tcnt_q != TW'(DONE_TIMEOUT-1))
               tcnt_d = tcnt_q + TW'(1);
            if (abort) begin
               state_d = S_IDLE;
            end else if (conv_done) begin
               state_d = S_IDLE;
               fd_d    = 1'b1;
            end
`ifdef FEEDER_TIMEOUT_EN
            else if (tcnt_q == TW'(DONE_TIMEOUT-1)) begin
               state_d = S_IDLE;
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_STREAM) || (state_d == S_WAIT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         tcnt_q  <= '0;
         start_q <= 1'b0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         fd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tcnt_q  <= tcnt_d;
         start_q <= start_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         fd_q    <= fd_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) mem_q[i] <= '0;
      end else if (wr_ok) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

`ifdef FEEDER_TIMEOUT_EN
   logic terr_q, terr_d;

   // conv_done on the expiry cycle wins, so only a done-less expiry sets the flag.
   always_comb begin
      terr_d = terr_q;
      if (state_q == S_IDLE && go)
         terr_d = 1'b0;
      else if (state_q == S_WAIT && !abort && !conv_done &&
               tcnt_q == TW'(DONE_TIMEOUT-1))
         terr_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) terr_q <= 1'b0;
      else     terr_q <= terr_d;
   end

   assign timeout_err = terr_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign conv_start = start_q;
   assign conv_data  = data_q;
   assign busy       = busy_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_conv2d_pixel_feeder.sv
// Directed bench for conv2d_pixel_feeder (5x5 frame, 8-bit pixels).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.

module tb_conv2d_pixel_feeder;

   localparam int N  = 25;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst, wr_en, go, abort, conv_done;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          conv_start, busy, frame_done, timeout_err;
   logic [7:0]    conv_data;

   int n_chk = 0;
   int n_ok  = 0;
   int model [N];

   always #5 clk = ~clk;

   conv2d_pixel_feeder #(.IMG_W(5), .IMG_H(5), .DATA_W(8), .DONE_TIMEOUT(64)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .go(go), .abort(abort), .conv_start(conv_start), .conv_data(conv_data),
      .conv_done(conv_done), .busy(busy), .frame_done(frame_done),
      .timeout_err(timeout_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_ok++;
      else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int base);
      for (int i = 0; i < N; i++) begin
         wr_en = 1'b1; wr_addr = AW'(i); wr_data = 8'(base + i);
         model[i] = (base + i) & 8'hff;
         step();
      end
      wr_en = 1'b0;
   endtask

   // Pulses go and checks the streamed pixels against model[].
   // stop_at >= 0 returns while pixel stop_at is on conv_data.
   // inject: a write at the go cycle (addr 0 = 55), a write to addr 20 = 99
   // mid-stream and conv_done during the stream, all of which must be ignored.
   task automatic stream(input string tag, input int stop_at, input bit inject);
      go = 1'b1;
      wr_en = inject; wr_addr = 0; wr_data = 55;
      step();
      go = 1'b0; wr_en = 1'b0;
      for (int k = 0; k < N; k++) begin
         chk({tag, "_start"}, conv_start, 1);
         chk({tag, "_data"}, conv_data, model[k]);
         if (k == stop_at) return;
         if (inject) begin
            wr_en = (k == 5); wr_addr = 20; wr_data = 99;
            conv_done = (k >= 3 && k <= 6);
         end
         step();
      end
      wr_en = 1'b0; conv_done = 1'b0;
      chk({tag, "_end_start"}, conv_start, 0);
      chk({tag, "_end_data"}, conv_data, 0);
      chk({tag, "_end_busy"}, busy, 1);
      chk({tag, "_end_fd"}, frame_done, 0);
   endtask

   task automatic finish_frame(input string tag);
      repeat (9) step();
      chk({tag, "_wait_busy"}, busy, 1);
      conv_done = 1'b1;
      step();
      conv_done = 1'b0;
      chk({tag, "_fd"}, frame_done, 1);
      chk({tag, "_busy_fall"}, busy, 0);
      step();
      chk({tag, "_fd_pulse"}, frame_done, 0);
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; go = 1'b0; abort = 1'b0; conv_done = 1'b0;
      wr_addr = '0; wr_data = '0;
      #1;
      chk("rst_start", conv_start, 0);
      chk("rst_data", conv_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fd", frame_done, 0);
      chk("rst_terr", timeout_err, 0);
      step(); step();
      rst = 1'b0;

      // frame 1: pixels 1..25
      load(1);
      stream("f1", -1, 1'b0);
      finish_frame("f1");

      // frame 2: replay with dropped writes and ignored conv_done
      stream("f2", -1, 1'b1);
      finish_frame("f2");

      // out-of-range write in IDLE is dropped; frame 3 must be unchanged
      wr_en = 1'b1; wr_addr = 25; wr_data = 7;
      step();
      wr_en = 1'b0;
      stream("f3", -1, 1'b0);
      chk("f3_pos21", model[20], 21);
      finish_frame("f3");

      // abort while conv_data == 10
      stream("f4", 9, 1'b0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("ab_start", conv_start, 0);
      chk("ab_data", conv_data, 0);
      chk("ab_busy", busy, 0);
      chk("ab_fd", frame_done, 0);
      conv_done = 1'b1;
      step();
      conv_done = 1'b0;
      chk("ab_done_ign_fd", frame_done, 0);
      chk("ab_done_ign_busy", busy, 0);

      // withheld conv_done
      stream("f5", -1, 1'b0);
`ifdef FEEDER_TIMEOUT_EN
      repeat (63) step();
      chk("to_pre_busy", busy, 1);
      chk("to_pre_terr", timeout_err, 0);
      step();
      chk("to_terr", timeout_err, 1);
      chk("to_busy", busy, 0);
      chk("to_fd", frame_done, 0);
      step();
      chk("to_sticky", timeout_err, 1);
      go = 1'b1;
      step();
      go = 1'b0;
      chk("to_go_clr", timeout_err, 0);
      chk("to_go_busy", busy, 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
`else
      repeat (70) step();
      chk("nto_busy", busy, 1);
      chk("nto_terr", timeout_err, 0);
      conv_done = 1'b1;
      step();
      conv_done = 1'b0;
      chk("nto_fd", frame_done, 1);
`endif
      step();

      // reset while conv_data == 13
      stream("f6", 12, 1'b0);
      rst = 1'b1;
      #1;
      chk("mr_start", conv_start, 0);
      chk("mr_data", conv_data, 0);
      chk("mr_busy", busy, 0);
      chk("mr_fd", frame_done, 0);
      chk("mr_terr", timeout_err, 0);
      step();
      rst = 1'b0;
      step(); step();
      chk("mr_no_start", conv_start, 0);
      chk("mr_idle_busy", busy, 0);

      // buffer was cleared by reset
      for (int i = 0; i < N; i++) model[i] = 0;
      stream("f7", -1, 1'b0);
      abort = 1'b1;
      step();
      abort = 1'b0;

      // reload different pixels; streams from pixel 0
      load(101);
      stream("f8", -1, 1'b0);
      finish_frame("f8");

      $display("%0d/%0d checks passed", n_ok, n_chk);
      $finish;
   end

endmodule
